// File: rtl/dsp_file_defs.sv
// Shared definitions for the DSP file server and the engines that poll it.
// FSM encodings, pointer width helper and error-flag bit positions.
`ifndef DSP_FILE_PTR_W
`define DSP_FILE_PTR_W(aw) ((aw) + 1)
`endif

package dsp_file_defs;

  typedef enum logic [1:0] {
    FILE_SRV_IDLE   = 2'd0,
    FILE_SRV_ACCESS = 2'd1,
    FILE_SRV_RESP   = 2'd2
  } file_srv_state_e;

  localparam int ERR_UNDERFLOW_BIT = 0;
  localparam int ERR_OVERFLOW_BIT  = 1;
  localparam int ERR_BAD_REQ_BIT   = 2;
  localparam int ERR_W             = 3;

endpackage

// File: rtl/dsp_file_ram.sv
// Single-port synchronous RAM backing all files.
// Read data register only moves on reads so it holds across writes.
module dsp_file_ram #(
  parameter int WORDS = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dsp_file_server.sv
// Responder for the DSP file interface: NUM_FILES circular FIFOs in one RAM.
// Optional macro DSP_FILE_SERVER_STATS_EN adds a serviced-request counter.
module dsp_file_server
  import dsp_file_defs::*;
#(
  parameter int NUM_FILES = 4,
  parameter int ADDR_W    = 6,
  parameter int dw        = 32
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  input  logic          file_write,
  input  logic [dw-1:0] file_write_data,
  output logic [dw-1:0] file_read_data,
  output logic          file_active,
  output logic [31:0]   rd_ptr,
  output logic [31:0]   wr_ptr,
  input  logic          flush,
  input  logic [7:0]    flush_file,
  output logic          err_underflow,
  output logic          err_overflow,
  output logic          err_bad_req,
  output logic [31:0]   stat_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = `DSP_FILE_PTR_W(ADDR_W);
  localparam int FW    = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int RAW   = FW + ADDR_W;
  localparam logic [7:0] NF = 8'(NUM_FILES);

  file_srv_state_e state_q, state_d;

  logic [PW-1:0]    rp_q [NUM_FILES];
  logic [PW-1:0]    wp_q [NUM_FILES];
  logic [FW-1:0]    fidx_q;
  logic             rd_q, wr_q, bad_q;
  logic [dw-1:0]    wdata_q;
  logic             active_q;
  logic             rzero_q;
  logic [ERR_W-1:0] err_q;

  logic          req, bad_now, acc;
  logic [PW-1:0] crp, cwp;
  logic          empty, full, rd_ok, wr_ok;
  logic          ram_en, ram_we;
  logic [RAW-1:0] ram_addr;
  logic [dw-1:0] ram_rdata;

  assign req     = file_read | file_write;
  assign bad_now = (file_num >= NF) | (file_read & file_write);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= FILE_SRV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILE_SRV_IDLE:   if (req) state_d = FILE_SRV_ACCESS;
      FILE_SRV_ACCESS: state_d = FILE_SRV_RESP;
      FILE_SRV_RESP:   if (!req) state_d = FILE_SRV_IDLE;
      default:         state_d = FILE_SRV_IDLE;
    endcase
  end

  always_comb begin
    acc      = (state_q == FILE_SRV_ACCESS);
    crp      = rp_q[fidx_q];
    cwp      = wp_q[fidx_q];
    empty    = (crp == cwp);
    full     = (crp[ADDR_W-1:0] == cwp[ADDR_W-1:0]) &&
               (crp[ADDR_W] != cwp[ADDR_W]);
    rd_ok    = acc & rd_q & ~bad_q & ~empty;
    wr_ok    = acc & wr_q & ~bad_q & ~full;
    ram_en   = rd_ok | wr_ok;
    ram_we   = wr_ok;
    ram_addr = {fidx_q, rd_ok ? crp[ADDR_W-1:0] : cwp[ADDR_W-1:0]};
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      active_q <= 1'b0;
      rzero_q  <= 1'b1;
      err_q    <= '0;
      fidx_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      wdata_q  <= '0;
      for (int f = 0; f < NUM_FILES; f++) begin
        rp_q[f] <= '0;
        wp_q[f] <= '0;
      end
    end else begin
      active_q <= (state_d != FILE_SRV_IDLE);
      err_q    <= '0;
      if (state_q == FILE_SRV_IDLE && req) begin
        fidx_q  <= file_num[FW-1:0];
        rd_q    <= file_read;
        wr_q    <= file_write;
        bad_q   <= bad_now;
        wdata_q <= file_write_data;
      end
      if (acc) begin
        if (rd_q) rzero_q <= ~rd_ok;
        err_q[ERR_UNDERFLOW_BIT] <= rd_q & ~bad_q & empty;
        err_q[ERR_OVERFLOW_BIT]  <= wr_q & ~bad_q & full;
        err_q[ERR_BAD_REQ_BIT]   <= bad_q;
        if (rd_ok) rp_q[fidx_q] <= crp + PW'(1);
        if (wr_ok) wp_q[fidx_q] <= cwp + PW'(1);
      end
      // Flush lands after the increment so it wins on the same file
      if (flush && flush_file < NF) begin
        rp_q[flush_file[FW-1:0]] <= '0;
        wp_q[flush_file[FW-1:0]] <= '0;
      end
    end
  end

  dsp_file_ram #(
    .WORDS (NUM_FILES * DEPTH),
    .AW    (RAW),
    .DW    (dw)
  ) u_ram (
    .clk   (wb_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_ptr = '0;
    wr_ptr = '0;
    if (file_num < NF) begin
      rd_ptr[PW-1:0] = rp_q[file_num[FW-1:0]];
      wr_ptr[PW-1:0] = wp_q[file_num[FW-1:0]];
    end
  end

  assign file_read_data = rzero_q ? '0 : ram_rdata;
  assign file_active    = active_q;
  assign err_underflow  = err_q[ERR_UNDERFLOW_BIT];
  assign err_overflow   = err_q[ERR_OVERFLOW_BIT];
  assign err_bad_req    = err_q[ERR_BAD_REQ_BIT];

`ifdef DSP_FILE_SERVER_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      stat_q <= '0;
    end else if (rd_ok | wr_ok) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_dsp_file_server.sv
// Randomized self-checking bench for dsp_file_server.
// Reference model: per-file queues plus push/pop counts modulo 2*DEPTH.
module tb_dsp_file_server;

  localparam int NF    = 4;
  localparam int DEPTH = 64;
  localparam int PMOD  = 2 * DEPTH;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [7:0]  file_num = '0;
  logic        file_read = 1'b0;
  logic        file_write = 1'b0;
  logic [31:0] file_write_data = '0;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] rd_ptr, wr_ptr;
  logic        flush = 1'b0;
  logic [7:0]  flush_file = '0;
  logic        err_underflow, err_overflow, err_bad_req;
  logic [31:0] stat_count;

  dsp_file_server dut (
    .wb_clk          (wb_clk),
    .wb_rst          (wb_rst),
    .file_num        (file_num),
    .file_read       (file_read),
    .file_write      (file_write),
    .file_write_data (file_write_data),
    .file_read_data  (file_read_data),
    .file_active     (file_active),
    .rd_ptr          (rd_ptr),
    .wr_ptr          (wr_ptr),
    .flush           (flush),
    .flush_file      (flush_file),
    .err_underflow   (err_underflow),
    .err_overflow    (err_overflow),
    .err_bad_req     (err_bad_req),
    .stat_count      (stat_count)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq [NF][$];
  int          wcnt [NF];
  int          rcnt [NF];
  logic [31:0] m_last;
  int          m_stat;

  int          act_o, uf_o, of_o, br_o;
  logic [31:0] rdat_o;
  logic [31:0] e_data;
  int          e_uf, e_of, e_br;

  task automatic m_reset();
    for (int f = 0; f < NF; f++) begin
      mq[f].delete();
      wcnt[f] = 0;
      rcnt[f] = 0;
    end
    m_last = '0;
    m_stat = 0;
  endtask

  task automatic m_flush(input int f);
    if (f < NF) begin
      mq[f].delete();
      wcnt[f] = 0;
      rcnt[f] = 0;
    end
  endtask

  task automatic m_op(input int fn, input bit r, input bit w,
                      input logic [31:0] d);
    e_uf = 0;
    e_of = 0;
    e_br = 0;
    if (fn >= NF || (r && w)) begin
      e_br = 1;
      if (r) m_last = '0;
    end else if (r) begin
      if (mq[fn].size() == 0) begin
        e_uf = 1;
        m_last = '0;
      end else begin
        m_last = mq[fn].pop_front();
        rcnt[fn] = (rcnt[fn] + 1) % PMOD;
        m_stat++;
      end
    end else if (w) begin
      if (mq[fn].size() == DEPTH) begin
        e_of = 1;
      end else begin
        mq[fn].push_back(d);
        wcnt[fn] = (wcnt[fn] + 1) % PMOD;
        m_stat++;
      end
    end
    e_data = m_last;
  endtask

  // Compliant initiator: drop the request once file_active is seen
  task automatic drive(input logic [7:0] fn, input bit r, input bit w,
                       input logic [31:0] d, input bit fl,
                       input logic [7:0] ff);
    int n;
    @(negedge wb_clk);
    file_num = fn;
    file_read = r;
    file_write = w;
    file_write_data = d;
    act_o = 0;
    uf_o = 0;
    of_o = 0;
    br_o = 0;
    rdat_o = '0;
    n = 0;
    while (!file_active && n < 8) begin
      @(negedge wb_clk);
      n++;
    end
    file_read = 1'b0;
    file_write = 1'b0;
    if (fl) begin
      flush = 1'b1;
      flush_file = ff;
    end
    while (file_active && act_o < 8) begin
      act_o++;
      rdat_o = file_read_data;
      uf_o += int'(err_underflow);
      of_o += int'(err_overflow);
      br_o += int'(err_bad_req);
      @(negedge wb_clk);
      flush = 1'b0;
    end
    flush = 1'b0;
    m_op(int'(fn), r, w, d);
    if (fl) m_flush(int'(ff));
  endtask

  task automatic pulse_flush(input logic [7:0] ff);
    @(negedge wb_clk);
    flush = 1'b1;
    flush_file = ff;
    @(negedge wb_clk);
    flush = 1'b0;
    m_flush(int'(ff));
  endtask

  task automatic test_reset();
    checks++;
    if (file_active !== 1'b0 || file_read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got act=%0b data=%0h exp 0/0",
               file_active, file_read_data);
    end
    checks++;
    if ({err_underflow, err_overflow, err_bad_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err got %0b exp 000",
               {err_underflow, err_overflow, err_bad_req});
    end
    checks++;
    if (stat_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_stat got %0d exp 0", stat_count);
    end
    for (int f = 0; f < NF; f++) begin
      @(negedge wb_clk);
      file_num = 8'(f);
      #1;
      checks++;
      if (rd_ptr !== 32'd0 || wr_ptr !== 32'd0) begin
        errors++;
        $display("FAIL reset_ptr f%0d got %0d/%0d exp 0/0",
                 f, rd_ptr, wr_ptr);
      end
    end
  endtask

  task automatic test_basic();
    drive(8'd2, 0, 1, 32'h1111_0001, 0, 8'd0);
    checks++;
    if (act_o !== 2 || of_o !== 0) begin
      errors++;
      $display("FAIL basic_wr got act=%0d of=%0d exp 2/0", act_o, of_o);
    end
    drive(8'd2, 0, 1, 32'h1111_0002, 0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      drive(8'd2, 1, 0, 32'd0, 0, 8'd0);
      checks++;
      if (act_o !== 2 || rdat_o !== 32'h1111_0001 + 32'(k)) begin
        errors++;
        $display("FAIL basic_rd%0d got act=%0d data=%0h exp 2/%0h",
                 k, act_o, rdat_o, 32'h1111_0001 + 32'(k));
      end
    end
    #1;
    checks++;
    if (rd_ptr !== 32'd2 || wr_ptr !== 32'd2) begin
      errors++;
      $display("FAIL basic_ptr got %0d/%0d exp 2/2", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_underflow();
    drive(8'd1, 1, 0, 32'd0, 0, 8'd0);
    checks++;
    if (uf_o !== 1 || act_o !== 2 || rdat_o !== 32'd0) begin
      errors++;
      $display("FAIL underflow got uf=%0d act=%0d data=%0h exp 1/2/0",
               uf_o, act_o, rdat_o);
    end
    #1;
    checks++;
    if (rd_ptr !== 32'd0 || wr_ptr !== 32'd0) begin
      errors++;
      $display("FAIL underflow_ptr got %0d/%0d exp 0/0", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) drive(8'd0, 0, 1, 32'(i), 0, 8'd0);
    #1;
    checks++;
    if (wr_ptr !== 32'(wcnt[0]) || wr_ptr !== 32'd64) begin
      errors++;
      $display("FAIL fill_ptr got %0d exp 64", wr_ptr);
    end
    drive(8'd0, 0, 1, 32'hdead_beef, 0, 8'd0);
    #1;
    checks++;
    if (of_o !== 1 || act_o !== 2 || wr_ptr !== 32'd64) begin
      errors++;
      $display("FAIL overflow got of=%0d act=%0d wp=%0d exp 1/2/64",
               of_o, act_o, wr_ptr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(8'd0, 1, 0, 32'd0, 0, 8'd0);
      checks++;
      if (rdat_o !== 32'(i)) begin
        errors++;
        $display("FAIL pop%0d got %0h exp %0h", i, rdat_o, i);
      end
    end
    #1;
    checks++;
    if (rd_ptr !== 32'd64 || wr_ptr !== 32'd64) begin
      errors++;
      $display("FAIL drain_ptr got %0d/%0d exp 64/64", rd_ptr, wr_ptr);
    end
    drive(8'd0, 1, 0, 32'd0, 0, 8'd0);
    checks++;
    if (uf_o !== 1) begin
      errors++;
      $display("FAIL wrap_empty got uf=%0d exp 1", uf_o);
    end
    for (int i = 0; i < DEPTH; i++) drive(8'd0, 0, 1, $urandom, 0, 8'd0);
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (i >= DEPTH) drive(8'd0, 0, 1, $urandom, 0, 8'd0);
      drive(8'd0, 1, 0, 32'd0, 0, 8'd0);
      checks++;
      if (rdat_o !== e_data || uf_o !== 0) begin
        errors++;
        $display("FAIL wrap_pop%0d got %0h uf=%0d exp %0h", i,
                 rdat_o, uf_o, e_data);
      end
    end
    #1;
    checks++;
    if (rd_ptr !== 32'd10 || wr_ptr !== 32'd10) begin
      errors++;
      $display("FAIL wrap_ptr got %0d/%0d exp 10/10", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_bad_req();
    drive(8'd0, 0, 1, 32'h0bad_0000, 0, 8'd0);
    drive(8'd0, 1, 0, 32'd0, 0, 8'd0);
    drive(8'd7, 1, 0, 32'd0, 0, 8'd0);
    #1;
    checks++;
    if (br_o !== 1 || act_o !== 2 || rdat_o !== 32'd0) begin
      errors++;
      $display("FAIL bad_fnum got br=%0d act=%0d data=%0h exp 1/2/0",
               br_o, act_o, rdat_o);
    end
    checks++;
    if (rd_ptr !== 32'd0 || wr_ptr !== 32'd0) begin
      errors++;
      $display("FAIL bad_fnum_ptr got %0d/%0d exp 0/0", rd_ptr, wr_ptr);
    end
    drive(8'd2, 1, 1, 32'h1234_5678, 0, 8'd0);
    checks++;
    if (br_o !== 1 || act_o !== 2 || uf_o !== 0) begin
      errors++;
      $display("FAIL bad_rw got br=%0d act=%0d uf=%0d exp 1/2/0",
               br_o, act_o, uf_o);
    end
    for (int f = 0; f < NF; f++) begin
      @(negedge wb_clk);
      file_num = 8'(f);
      #1;
      checks++;
      if (rd_ptr !== 32'(rcnt[f]) || wr_ptr !== 32'(wcnt[f])) begin
        errors++;
        $display("FAIL bad_keep f%0d got %0d/%0d exp %0d/%0d",
                 f, rd_ptr, wr_ptr, rcnt[f], wcnt[f]);
      end
    end
  endtask

  task automatic test_flush();
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < 3; i++)
        drive(8'(f), 0, 1, $urandom, 0, 8'd0);
    drive(8'd3, 0, 1, $urandom, 1, 8'd3);
    #1;
    checks++;
    if (act_o !== 2 || rd_ptr !== 32'd0 || wr_ptr !== 32'd0) begin
      errors++;
      $display("FAIL flush_f3 got act=%0d ptr=%0d/%0d exp 2/0/0",
               act_o, rd_ptr, wr_ptr);
    end
    pulse_flush(8'd9);
    for (int f = 0; f < 3; f++) begin
      @(negedge wb_clk);
      file_num = 8'(f);
      #1;
      checks++;
      if (rd_ptr !== 32'(rcnt[f]) || wr_ptr !== 32'(wcnt[f])) begin
        errors++;
        $display("FAIL flush_keep f%0d got %0d/%0d exp %0d/%0d",
                 f, rd_ptr, wr_ptr, rcnt[f], wcnt[f]);
      end
      while (mq[f].size() > 0) begin
        drive(8'(f), 1, 0, 32'd0, 0, 8'd0);
        checks++;
        if (rdat_o !== e_data) begin
          errors++;
          $display("FAIL flush_data f%0d got %0h exp %0h",
                   f, rdat_o, e_data);
        end
      end
    end
  endtask

  task automatic test_random();
    int fn, kind;
    bit fl;
    for (int i = 0; i < 160; i++) begin
      fn = $urandom_range(0, NF - 1);
      kind = $urandom_range(0, 2);
      fl = ($urandom_range(0, 15) == 0);
      drive(8'(fn), kind == 0, kind != 0, $urandom, fl,
            8'($urandom_range(0, NF - 1)));
      #1;
      checks++;
      if ({act_o, uf_o, of_o, br_o} !== {32'd2, e_uf, e_of, e_br}) begin
        errors++;
        $display("FAIL rnd_hs%0d got %0d/%0d/%0d/%0d exp 2/%0d/%0d/%0d",
                 i, act_o, uf_o, of_o, br_o, e_uf, e_of, e_br);
      end
      checks++;
      if (rdat_o !== e_data || file_read_data !== e_data) begin
        errors++;
        $display("FAIL rnd_data%0d got %0h/%0h exp %0h",
                 i, rdat_o, file_read_data, e_data);
      end
      checks++;
      if (rd_ptr !== 32'(rcnt[fn]) || wr_ptr !== 32'(wcnt[fn])) begin
        errors++;
        $display("FAIL rnd_ptr%0d got %0d/%0d exp %0d/%0d",
                 i, rd_ptr, wr_ptr, rcnt[fn], wcnt[fn]);
      end
    end
  endtask

  task automatic test_stats();
    int base;
    pulse_flush(8'd3);
    base = m_stat;
    for (int i = 0; i < 3; i++) drive(8'd3, 0, 1, $urandom, 0, 8'd0);
    for (int i = 0; i < 3; i++) drive(8'd3, 1, 0, 32'd0, 0, 8'd0);
    drive(8'd3, 1, 0, 32'd0, 0, 8'd0);
    checks++;
    if (uf_o !== 1) begin
      errors++;
      $display("FAIL stat_uf got %0d exp 1", uf_o);
    end
    for (int i = 0; i < 2; i++) drive(8'd3, 0, 1, $urandom, 0, 8'd0);
    checks++;
`ifdef DSP_FILE_SERVER_STATS_EN
    if (stat_count !== 32'(m_stat) || m_stat - base != 8) begin
      errors++;
      $display("FAIL stat_count got %0d exp %0d", stat_count, m_stat);
    end
`else
    if (stat_count !== 32'd0) begin
      errors++;
      $display("FAIL stat_count got %0d exp 0", stat_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge wb_clk);
    file_num = 8'd1;
    file_write = 1'b1;
    file_write_data = 32'hcafe_0001;
    n = 0;
    while (!file_active && n < 8) begin
      @(negedge wb_clk);
      n++;
    end
    wb_rst = 1'b1;
    file_write = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (file_active !== 1'b0 || file_read_data !== 32'd0 ||
        rd_ptr !== 32'd0 || wr_ptr !== 32'd0 || stat_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got act=%0b data=%0h ptr=%0d/%0d st=%0d",
               file_active, file_read_data, rd_ptr, wr_ptr, stat_count);
    end
    drive(8'd1, 0, 1, 32'hcafe_0002, 0, 8'd0);
    drive(8'd1, 1, 0, 32'd0, 0, 8'd0);
    checks++;
    if (act_o !== 2 || rdat_o !== 32'hcafe_0002) begin
      errors++;
      $display("FAIL reset_mid_rd got act=%0d data=%0h exp 2/cafe0002",
               act_o, rdat_o);
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_underflow();
    test_wrap();
    test_bad_req();
    test_flush();
    test_random();
    test_stats();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
